// File: rtl/slave_serial_port.sv
// Serial slave port: bit-serial address/data in, bit-serial read data out,
// with a programmable read wait during which the slave requests a bus split.
module slave_serial_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int MEM_DEPTH = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] slave_delay,
    input  logic       read_en,
    input  logic       write_en,
    input  logic       master_valid,
    input  logic       rx_address,
    input  logic       rx_data,
    input  logic       master_ready,
    output logic       slave_ready,
    output logic       slave_valid,
    output logic       tx_data,
    output logic       split_en
);

    localparam int MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        COMMIT = 3'd3,
        WAIT   = 3'd4,
        RDATA  = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         bit_cnt;
    logic [5:0]            wait_cnt;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [DATA_LEN-1:0]   data_q;
    logic                  is_read;
    logic                  start;
    logic                  addr_last;
    logic                  data_last;
    logic [AW-1:0]         mem_idx;
    logic [DATA_LEN-1:0]   rd_word;
    logic                  tx_bit;

    logic [DATA_LEN-1:0]   mem [0:MEM_DEPTH-1];

    assign start     = master_valid & (read_en ^ write_en);
    assign addr_last = (bit_cnt == ADDR_LAST);
    assign data_last = (bit_cnt == DATA_LAST);
    assign mem_idx   = AW'(addr_q % MEM_DEPTH);
    assign rd_word   = mem[mem_idx];
    assign tx_bit    = |(rd_word & (DATA_LEN'(1) << bit_cnt));

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = ADDR;
            ADDR: begin
                if (!master_valid)
                    state_nxt = IDLE;
                else if (addr_last) begin
                    if (!is_read)                state_nxt = WDATA;
                    else if (slave_delay == 6'd0) state_nxt = RDATA;
                    else                         state_nxt = WAIT;
                end
            end
            WDATA: begin
                if (!master_valid)  state_nxt = IDLE;
                else if (data_last) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            WAIT:   if (wait_cnt == 6'd1) state_nxt = RDATA;
            RDATA:  if (master_ready && data_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are a pure function of state so they follow reset immediately
    always_comb begin
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        tx_data     = 1'b0;
        split_en    = 1'b0;
        case (state)
            IDLE:  slave_ready = 1'b1;
            WAIT:  split_en    = 1'b1;
            RDATA: begin
                slave_valid = 1'b1;
                tx_data     = tx_bit;
            end
            default: ;
        endcase
    end

    // datapath: address/data shift in LSB first, bit counter, wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            is_read  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr_q  <= {rx_address, {(ADDR_LEN-1){1'b0}}};
                    data_q  <= '0;
                    is_read <= read_en;
                    bit_cnt <= CNT_ONE;
                end
                ADDR: begin
                    if (!master_valid)
                        bit_cnt <= '0;
                    else begin
                        addr_q <= {rx_address, addr_q[ADDR_LEN-1:1]};
                        if (addr_last) begin
                            bit_cnt  <= '0;
                            wait_cnt <= slave_delay;
                        end else
                            bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                WDATA: begin
                    if (!master_valid)
                        bit_cnt <= '0;
                    else begin
                        data_q  <= {rx_data, data_q[DATA_LEN-1:1]};
                        bit_cnt <= data_last ? '0 : bit_cnt + CNT_ONE;
                    end
                end
                WAIT:  wait_cnt <= wait_cnt - 6'd1;
                RDATA: if (master_ready) bit_cnt <= data_last ? '0 : bit_cnt + CNT_ONE;
                default: ;
            endcase
        end
    end

    // storage is deliberately not reset; a reset during a transfer can never reach COMMIT
    always_ff @(posedge clk) begin
        if (state == COMMIT) mem[mem_idx] <= data_q;
    end

endmodule

// File: doc/slave_serial_port.md
SLAVE_SERIAL_PORT -- requirements
Module: slave_serial_port

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_LEN, 12, address bits per transfer; DATA_LEN, 8, data bits per word; MEM_DEPTH, 4096, words of internal storage.
REQ-002 Port `clk`, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `slave_delay`, input, 6 bits: read wait cycles before the first response bit.
REQ-005 Port `read_en`, input, 1 bit: read request qualifier.
REQ-006 Port `write_en`, input, 1 bit: write request qualifier.
REQ-007 Port `master_valid`, input, 1 bit: master is driving valid address/data bits.
REQ-008 Port `rx_address`, input, 1 bit: serial address, LSB first.
REQ-009 Port `rx_data`, input, 1 bit: serial write data, LSB first.
REQ-010 Port `master_ready`, input, 1 bit: master accepts a response bit this cycle.
REQ-011 Port `slave_ready`, output, 1 bit: port idle and able to accept a request.
REQ-012 Port `slave_valid`, output, 1 bit: `tx_data` holds a valid read bit.
REQ-013 Port `tx_data`, output, 1 bit: serial read data, LSB first.
REQ-014 Port `split_en`, output, 1 bit: slave requests bus split during the read wait.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, WDATA, COMMIT, WAIT, RDATA.
- IDLE: `slave_ready`=1; all other outputs 0.
REQ-016 A transfer SHALL start when all of these hold in IDLE:
- `master_valid`=1;
- exactly one of `read_en`/`write_en` is 1;
- `slave_ready`=1.
On that cycle, address bit 0 is sampled, the command is latched, and the FSM enters ADDR.
REQ-017 ADDR SHALL sample one `rx_address` bit per cycle while `master_valid`=1, until ADDR_LEN bits total.
- Write: next state WDATA.
- Read: next state WAIT.
REQ-018 WDATA SHALL sample DATA_LEN `rx_data` bits LSB first while `master_valid`=1, then enter COMMIT.
REQ-019 COMMIT SHALL write the assembled word to memory[address mod MEM_DEPTH] in exactly one cycle, then return to IDLE.
REQ-020 In ADDR or WDATA, a cycle with `master_valid`=0 SHALL abort the transfer.
- FSM returns to IDLE; no memory write; bit counters cleared.
REQ-021 WAIT SHALL last exactly `slave_delay` cycles, using a 6-bit down-counter loaded on entry.
- `split_en`=1 throughout WAIT when `slave_delay`≠0.
- `slave_delay`=0: WAIT lasts zero cycles and RDATA follows ADDR directly.
REQ-022 In RDATA, `slave_valid`=1 and `tx_data` = the current bit of memory[address], LSB first.
- The bit index SHALL advance only on cycles with `master_ready`=1.
- While `master_ready`=0, the current bit is held.
REQ-023 After DATA_LEN accepted bits, RDATA SHALL deassert `slave_valid` and return to IDLE.
REQ-024 `slave_ready` SHALL be 0 in every non-IDLE state.
REQ-025 `split_en` SHALL be 0 outside WAIT.
REQ-026 Any IDLE cycle not meeting REQ-016 SHALL be ignored, with no state change. This includes `read_en`=`write_en`=1 and `master_valid`=1 with no command.
REQ-027 `slave_delay` SHALL be sampled only on WAIT entry; changes during WAIT have no effect.
REQ-028 Latency from the last address bit to the first `slave_valid` SHALL be `slave_delay`+1 cycles.
REQ-029 Write occupancy SHALL be ADDR_LEN+DATA_LEN+1 cycles from the start to the return of `slave_ready`.
REQ-030 Bit counters SHALL be wide enough for max(ADDR_LEN, DATA_LEN) with no wrap.
- Address bits beyond log2(MEM_DEPTH) SHALL be ignored.
REQ-031 Memory contents SHALL not be initialised by reset; reads of unwritten locations return an undefined value.

Reset
REQ-032 On `reset`=1, regardless of clock, the block SHALL immediately:
- set state to IDLE;
- set `slave_ready`=1 and `slave_valid`=0, `tx_data`=0, `split_en`=0;
- clear counters, address and data registers.
REQ-033 Reset mid-transfer SHALL discard the transfer with no memory write; memory contents are retained.

Verification
REQ-034 Write 0xA5 to address 0x123, then read 0x123 with `slave_delay`=0 and `master_ready`=1 throughout.
- Required: `slave_valid` 1 for 8 cycles; `tx_data` sequence 1,0,1,0,0,1,0,1; `split_en` never 1.
REQ-035 Read with `slave_delay`=10.
- Required: `split_en`=1 for exactly 10 cycles; first `slave_valid` 11 cycles after the last address bit.
REQ-036 Read with `master_ready` low for 3 cycles after bit 2.
- Required: bit 2 held 4 cycles; all 8 bits correct; total RDATA length 11 cycles.
REQ-037 Write to 0x050 with `master_valid` dropped after 5 address bits.
- Required: IDLE next cycle and `slave_ready`=1; a following read of 0x050 returns the prior contents.
REQ-038 Assert `reset` during WDATA bit 4.
- Required: outputs take reset values asynchronously; no memory update.
REQ-039 Request with `read_en`=`write_en`=1.
- Required: ignored; `slave_ready` stays 1.
